// File: rtl/subcore_mem_link.sv
// Main-core initiator for one sub-core data memory: block writes over the two write
// lanes (u/l) and interlocked block reads through the sub-core fetch port.
module subcore_mem_link #(
    parameter int SUB_AW    = 17,
    parameter int LEN_W     = 16,
    parameter int FETCH_LAT = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_read,
    input  logic [SUB_AW-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [31:0]       wr_data_u,
    input  logic [31:0]       wr_data_l,
    output logic              sub_u_we,
    output logic              sub_l_we,
    output logic [31:0]       sub_u_addr,
    output logic [31:0]       sub_l_addr,
    output logic [31:0]       sub_u_din,
    output logic [31:0]       sub_l_din,
    output logic              sub_interlock,
    output logic [31:0]       sub_fetch_addr,
    input  logic [31:0]       sub_fetch_result,
    output logic              rd_valid,
    output logic [31:0]       rd_data,
    output logic              done
);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_RD_ISSUE, S_RD_DRAIN, S_DONE} state_t;

    localparam logic [LEN_W:0] ONE = (LEN_W+1)'(1);
    localparam logic [LEN_W:0] TWO = (LEN_W+1)'(2);

    state_t                state_q, state_d;
    logic [SUB_AW-1:0]     addr_q, addr_d;
    logic [LEN_W:0]        left_q, left_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  wr_ready_q, wr_ready_d;
    logic                  u_we_q, u_we_d, l_we_q, l_we_d;
    logic [SUB_AW-1:0]     u_addr_q, u_addr_d, l_addr_q, l_addr_d;
    logic [31:0]           u_din_q, u_din_d, l_din_q, l_din_d;
    logic                  interlock_q, interlock_d;
    logic [SUB_AW-1:0]     fetch_addr_q, fetch_addr_d;
    logic [FETCH_LAT-1:0]  pipe_q, pipe_d, pipe_shift;
    logic                  push;
    logic                  rd_valid_q, rd_valid_d;
    logic [31:0]           rd_data_q, rd_data_d;
    logic                  done_q, done_d;

    always_comb begin
        // NOTE: every _d takes a default before the case so no path can infer a latch.
        state_d      = state_q;
        addr_d       = addr_q;
        left_d       = left_q;
        cmd_ready_d  = 1'b0;
        wr_ready_d   = 1'b0;
        u_we_d       = 1'b0;
        l_we_d       = 1'b0;
        u_addr_d     = u_addr_q;
        l_addr_d     = l_addr_q;
        u_din_d      = u_din_q;
        l_din_d      = l_din_q;
        interlock_d  = 1'b0;
        fetch_addr_d = fetch_addr_q;
        done_d       = 1'b0;
        push         = 1'b0;
        pipe_shift   = pipe_q << 1;

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr;
                    left_d      = {1'b0, cmd_len};
                    if (cmd_len == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (cmd_read) begin
                        state_d      = S_RD_ISSUE;
                        interlock_d  = 1'b1;
                        fetch_addr_d = cmd_addr;
                    end else begin
                        state_d    = S_WRITE;
                        wr_ready_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                wr_ready_d = 1'b1;
                if (wr_valid && wr_ready_q) begin
                    u_we_d   = 1'b1;
                    u_addr_d = addr_q;
                    u_din_d  = wr_data_u;
                    // The lower lane stays quiet on the trailing half-beat of an odd length.
                    l_we_d   = (left_q >= TWO);
                    l_addr_d = addr_q + SUB_AW'(1);
                    l_din_d  = wr_data_l;
                    addr_d   = addr_q + SUB_AW'(2);
                    if (left_q <= TWO) begin
                        left_d     = '0;
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        wr_ready_d = 1'b0;
                    end else begin
                        left_d = left_q - TWO;
                    end
                end
            end
            S_RD_ISSUE: begin
                interlock_d = 1'b1;
                push        = 1'b1;
                if (left_q == ONE) begin
                    left_d  = '0;
                    state_d = S_RD_DRAIN;
                end else begin
                    left_d       = left_q - ONE;
                    fetch_addr_d = fetch_addr_q + SUB_AW'(1);
                end
            end
            S_RD_DRAIN: begin
                interlock_d = 1'b1;
                if (pipe_shift == '0) begin
                    interlock_d = 1'b0;
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                end
            end
            S_DONE: begin
                cmd_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                cmd_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
        endcase

        pipe_d     = pipe_shift | FETCH_LAT'(push);
        rd_valid_d = pipe_q[FETCH_LAT-1];
        rd_data_d  = pipe_q[FETCH_LAT-1] ? sub_fetch_result : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            left_q       <= '0;
            cmd_ready_q  <= 1'b1;
            wr_ready_q   <= 1'b0;
            u_we_q       <= 1'b0;
            l_we_q       <= 1'b0;
            u_addr_q     <= '0;
            l_addr_q     <= '0;
            u_din_q      <= '0;
            l_din_q      <= '0;
            interlock_q  <= 1'b0;
            fetch_addr_q <= '0;
            pipe_q       <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            left_q       <= left_d;
            cmd_ready_q  <= cmd_ready_d;
            wr_ready_q   <= wr_ready_d;
            u_we_q       <= u_we_d;
            l_we_q       <= l_we_d;
            u_addr_q     <= u_addr_d;
            l_addr_q     <= l_addr_d;
            u_din_q      <= u_din_d;
            l_din_q      <= l_din_d;
            interlock_q  <= interlock_d;
            fetch_addr_q <= fetch_addr_d;
            pipe_q       <= pipe_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            done_q       <= done_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign wr_ready       = wr_ready_q;
    assign sub_u_we       = u_we_q;
    assign sub_l_we       = l_we_q;
    assign sub_u_addr     = 32'(u_addr_q);
    assign sub_l_addr     = 32'(l_addr_q);
    assign sub_u_din      = u_din_q;
    assign sub_l_din      = l_din_q;
    assign sub_interlock  = interlock_q;
    assign sub_fetch_addr = 32'(fetch_addr_q);
    assign rd_valid       = rd_valid_q;
    assign rd_data        = rd_data_q;
    assign done           = done_q;

endmodule

// File: tb/tb_subcore_mem_link.sv
// Randomized bench for subcore_mem_link: a sub-core memory/fetch model plus a
// word-level reference of what each command should produce and when.
module tb_subcore_mem_link;

    localparam int SUB_AW    = 17;
    localparam int LEN_W     = 16;
    localparam int FETCH_LAT = 2;
    localparam int AMASK     = (1 << SUB_AW) - 1;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_read = 1'b0;
    logic [SUB_AW-1:0] cmd_addr = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [31:0]       wr_data_u = '0;
    logic [31:0]       wr_data_l = '0;
    logic              sub_u_we, sub_l_we;
    logic [31:0]       sub_u_addr, sub_l_addr, sub_u_din, sub_l_din;
    logic              sub_interlock;
    logic [31:0]       sub_fetch_addr;
    logic [31:0]       sub_fetch_result;
    logic              rd_valid;
    logic [31:0]       rd_data;
    logic              done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    subcore_mem_link #(.SUB_AW(SUB_AW), .LEN_W(LEN_W), .FETCH_LAT(FETCH_LAT)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data_u(wr_data_u), .wr_data_l(wr_data_l),
        .sub_u_we(sub_u_we), .sub_l_we(sub_l_we),
        .sub_u_addr(sub_u_addr), .sub_l_addr(sub_l_addr),
        .sub_u_din(sub_u_din), .sub_l_din(sub_l_din),
        .sub_interlock(sub_interlock), .sub_fetch_addr(sub_fetch_addr),
        .sub_fetch_result(sub_fetch_result),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] seed_word(input int a);
        logic [31:0] av;
        av = a;
        return (av * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // Sub-core: data memory written by the lanes, fetch answers FETCH_LAT cycles later.
    logic [31:0] sub_mem [int];
    logic        f_v1 = 1'b0;
    logic [31:0] f_a1 = '0;
    logic [31:0] f_d2 = '0;

    always @(posedge clk) begin
        if (sub_u_we) sub_mem[int'(sub_u_addr)] = sub_u_din;
        if (sub_l_we) sub_mem[int'(sub_l_addr)] = sub_l_din;
    end

    always @(posedge clk) begin
        f_v1 <= sub_interlock;
        f_a1 <= sub_fetch_addr;
        if (!f_v1)                         f_d2 <= 32'hBAD0_BAD0;
        else if (sub_mem.exists(int'(f_a1))) f_d2 <= sub_mem[int'(f_a1)];
        else                               f_d2 <= seed_word(int'(f_a1));
    end
    assign sub_fetch_result = f_d2;

    // Reference view of the sub-core memory, updated from commanded writes only.
    logic [31:0] ref_mem [int];
    function automatic logic [31:0] ref_rd(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return seed_word(a);
    endfunction

    // Monitor: everything observable, stamped with the cycle number.
    ev_t obs_u[$], obs_l[$], obs_rd[$];
    int  ilk_cnt = 0, ilk_first = 0, ilk_last = 0, done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sub_u_we) obs_u.push_back('{cyc, sub_u_addr, sub_u_din});
        if (sub_l_we) obs_l.push_back('{cyc, sub_l_addr, sub_l_din});
        if (rd_valid) obs_rd.push_back('{cyc, 32'h0, rd_data});
        if (sub_interlock) begin
            if (ilk_cnt == 0) ilk_first = cyc;
            ilk_last = cyc;
            ilk_cnt++;
        end
        if (done) done_cnt++;
    end

    task automatic clear_mon();
        obs_u.delete();
        obs_l.delete();
        obs_rd.delete();
        ilk_cnt  = 0;
        done_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] beat_u[$], beat_l[$];

    task automatic fill_beats(input int n);
        beat_u.delete();
        beat_l.delete();
        for (int i = 0; i < n; i++) begin
            beat_u.push_back($urandom);
            beat_l.push_back($urandom);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, cmd_ready, 1);
    endtask

    // gap: 0 = beat every cycle, 1 = beat one cycle in three, 2 = random gaps.
    task automatic run_cmd(input string tag, input bit rd, input int a, input int l, input int gap);
        int  beats, acc, n, phase, last_edge, exp_done, xr, xi;
        bit  took;
        ev_t exp_u[$], exp_l[$];

        wait_ready(tag);
        clear_mon();
        cmd_valid = 1'b1;
        cmd_read  = rd;
        cmd_addr  = SUB_AW'(a);
        cmd_len   = LEN_W'(l);
        tick();
        acc       = cyc;
        cmd_valid = 1'b0;
        cmd_read  = 1'($urandom);
        cmd_addr  = SUB_AW'($urandom);
        cmd_len   = LEN_W'($urandom);
        last_edge = acc;
        beats     = rd ? 0 : (l + 1) / 2;
        phase     = 0;

        for (int i = 0; i < beats; i++) begin
            n    = 0;
            took = 1'b0;
            while (!took && n < 300) begin
                case (gap)
                    0:       wr_valid = 1'b1;
                    1:       wr_valid = (phase % 3 == 2);
                    default: wr_valid = ($urandom_range(0, 2) != 0);
                endcase
                phase++;
                wr_data_u = wr_valid ? beat_u[i] : $urandom;
                wr_data_l = wr_valid ? beat_l[i] : $urandom;
                took = wr_valid && wr_ready;
                tick();
                n++;
            end
            if (!took) begin
                check({tag, "_beat_timeout"}, took, 1);
                break;
            end
            last_edge = cyc;
            exp_u.push_back('{cyc, 32'((a + 2*i) & AMASK), beat_u[i]});
            if (2*i + 1 < l) exp_l.push_back('{cyc, 32'((a + 2*i + 1) & AMASK), beat_l[i]});
        end
        wr_valid = 1'b0;

        n = 0;
        while (!done && n < l + 64) begin
            if (rd) begin
                wr_valid  = 1'($urandom);
                wr_data_u = $urandom;
                wr_data_l = $urandom;
            end
            tick();
            n++;
        end
        wr_valid = 1'b0;
        check({tag, "_done"}, done, 1);
        exp_done = (rd && l > 0) ? acc + l + FETCH_LAT : last_edge;
        check({tag, "_done_cyc"}, cyc, exp_done);
        tick();
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_b2b_ready"}, cmd_ready, 1);
        check({tag, "_done_cnt"}, done_cnt, 1);

        check({tag, "_u_cnt"}, obs_u.size(), exp_u.size());
        check({tag, "_l_cnt"}, obs_l.size(), exp_l.size());
        for (int i = 0; i < exp_u.size() && i < obs_u.size(); i++) begin
            check({tag, "_u_cyc"},  obs_u[i].cyc,  exp_u[i].cyc);
            check({tag, "_u_addr"}, obs_u[i].addr, exp_u[i].addr);
            check({tag, "_u_data"}, obs_u[i].data, exp_u[i].data);
        end
        for (int i = 0; i < exp_l.size() && i < obs_l.size(); i++) begin
            check({tag, "_l_cyc"},  obs_l[i].cyc,  exp_l[i].cyc);
            check({tag, "_l_addr"}, obs_l[i].addr, exp_l[i].addr);
            check({tag, "_l_data"}, obs_l[i].data, exp_l[i].data);
        end

        xr = rd ? l : 0;
        xi = (rd && l > 0) ? l + FETCH_LAT : 0;
        check({tag, "_rd_cnt"}, obs_rd.size(), xr);
        for (int k = 0; k < xr && k < obs_rd.size(); k++) begin
            check({tag, "_rd_data"}, obs_rd[k].data, ref_rd((a + k) & AMASK));
            check({tag, "_rd_cyc"},  obs_rd[k].cyc,  acc + FETCH_LAT + 1 + k);
        end
        check({tag, "_ilk_cnt"}, ilk_cnt, xi);
        if (xi > 0) begin
            check({tag, "_ilk_first"}, ilk_first, acc);
            check({tag, "_ilk_last"},  ilk_last,  acc + xi - 1);
        end

        foreach (exp_u[i]) ref_mem[int'(exp_u[i].addr)] = exp_u[i].data;
        foreach (exp_l[i]) ref_mem[int'(exp_l[i].addr)] = exp_l[i].data;
    endtask

    task automatic reset_abort();
        wait_ready("abort");
        clear_mon();
        cmd_valid = 1'b1;
        cmd_read  = 1'b1;
        cmd_addr  = SUB_AW'($urandom);
        cmd_len   = LEN_W'(10);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("abort_ilk_before", sub_interlock, 1);
        rstn = 1'b0;
        tick();
        check("abort_ilk",       sub_interlock, 0);
        check("abort_rd_valid",  rd_valid, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_done",      done, 0);
        rstn = 1'b1;
        repeat (6) tick();
        check("abort_no_done",   done_cnt, 0);
        check("abort_ilk_after", sub_interlock, 0);
        check("abort_idle",      cmd_ready, 1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at 2ms, required finish");
        $fatal(1);
    end

    initial begin
        int rd, a, l, g;

        rstn = 1'b0;
        repeat (3) tick();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_wr_ready",  wr_ready, 0);
        check("rst_we",        {sub_u_we, sub_l_we}, 0);
        check("rst_ilk",       sub_interlock, 0);
        check("rst_rd_valid",  rd_valid, 0);
        check("rst_done",      done, 0);
        check("rst_u_addr",    sub_u_addr, 0);
        rstn = 1'b1;
        tick();

        beat_u = '{32'hAAAA_0001, 32'hCCCC_0003};
        beat_l = '{32'hBBBB_0002, 32'hDDDD_0004};
        run_cmd("wr_basic", 0, 'h10, 4, 0);

        fill_beats(2);
        run_cmd("wr_wrap", 0, 'h1FFFF, 3, 0);

        run_cmd("rd_basic", 1, 'h20, 5, 0);

        fill_beats(3);
        run_cmd("wr_gaps", 0, 'h300, 6, 1);

        run_cmd("rd_len0", 1, 'h40, 0, 0);
        run_cmd("wr_len0", 0, 'h40, 0, 0);

        run_cmd("rd_back", 1, 'h10, 4, 0);
        run_cmd("rd_wrap", 1, 'h1FFFE, 4, 0);

        reset_abort();

        for (int t = 0; t < 30; t++) begin
            rd = $urandom_range(0, 1);
            a  = ($urandom_range(0, 3) == 0) ? AMASK - $urandom_range(0, 5)
                                              : int'($urandom_range(0, AMASK));
            l  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 13);
            g  = $urandom_range(0, 2);
            fill_beats((l + 1) / 2);
            run_cmd($sformatf("rnd%0d", t), rd[0], a, l, g);
        end

        fill_beats(32768);
        run_cmd("wr_maxlen", 0, 'h1F000, 65535, 0);
        run_cmd("rd_after_max", 1, 'h1F000 + 65530 - AMASK - 1, 5, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
